// File: rtl/cpu_pkg.sv
// Shared opcode values, instruction field positions and fetch state encoding
// for the instruction fetch path.
package cpu_pkg;

  localparam logic [5:0] OP_LW    = 6'd0;
  localparam logic [5:0] OP_SW    = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_RTYPE = 6'd10;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int JIDX_W    = 26;
  localparam int IMM_HI    = 15;
  localparam int IMM_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump,
// with jump taking priority over branch.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [JIDX_W-1:0] i_target_field,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic              i_jump,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_branch_off;
  logic [ADDR_W-1:0] w_branch_target;
  logic [ADDR_W-1:0] w_jump_target;

  assign o_pc_plus4 = i_pc + ADDR_W'(4);

  // Word offset: sign-extended 16-bit immediate scaled by 4.
  assign w_branch_off = {{(ADDR_W-IMM_W-2){i_target_field[IMM_HI]}},
                         i_target_field[IMM_HI:0], 2'b00};
  assign w_branch_target = o_pc_plus4 + w_branch_off;
  assign w_jump_target   = {o_pc_plus4[ADDR_W-1:JIDX_W+2], i_target_field, 2'b00};

  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: one outstanding memory read, holds the fetched word
// for decode under a valid/ready handshake, then redirects the PC.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4
);

  // Clearing the low bits here keeps every derived address word-aligned.
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_out;
  logic [INSTR_W-1:0] r_instr;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic [ADDR_W-1:0]  w_next_pc;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .i_pc          (r_pc_out),
    .i_target_field(r_instr[JIDX_W-1:0]),
    .i_branch      (branch),
    .i_zero        (zero),
    .i_jump        (jump),
    .o_pc_plus4    (pc_plus4),
    .o_next_pc     (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC_ALIGNED;
      r_pc_out      <= RESET_PC_ALIGNED;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_pc;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Dropping en here still lets the held word finish its handshake.
          if (instr_ready) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= en;
            r_state       <= en ? ST_REQ : ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_HI:OPCODE_LO];
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc_out;

endmodule
